// File: rtl/fetch_unit.sv
// Instruction fetch front end: holds the PC, issues one outstanding imem request
// at a time, buffers a single fetched word and squashes stale fetches on redirect.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FULL
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] target;

  assign target = redirect_target & ~XLEN'(3);

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = target;
      end

      REQ: begin
        // An accepted request always belongs to the old pc; a simultaneous
        // redirect marks its response as stale.
        if (imem_ready) begin
          state_d = WAIT;
          if (redirect) begin
            drop_d = 1'b1;
            pc_d   = target;
          end
        end else if (redirect) begin
          pc_d = target;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = REQ;
            if (redirect) pc_d = target;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = FULL;
          end
        end else if (redirect) begin
          pc_d   = target;
          drop_d = 1'b1;
        end
      end

      FULL: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          pc_d          = target;
          state_d       = REQ;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          pc_d          = instr_pc_q + XLEN'(4);
          state_d       = REQ;
        end
      end

      default: begin
        state_d       = IDLE;
        drop_d        = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked against a transaction-level model every cycle.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: fetch progress expressed as facts about the transaction,
  // not as a state machine.
  bit          m_started, m_pending, m_stale, m_buf_valid;
  logic [31:0] m_pc, m_buf, m_buf_pc;

  // Memory environment: at most one accepted request awaiting its response.
  bit          mem_busy, mem_fixed, mem_rand;
  int          mem_cnt, mem_delay;
  logic [31:0] mem_data, mem_fixed_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_started   = 0;
    m_pending   = 0;
    m_stale     = 0;
    m_buf_valid = 0;
    m_pc        = RESET_PC;
    mem_busy    = 0;
    mem_fixed   = 0;
  endtask

  task automatic compare_model();
    bit exp_req;
    exp_req = m_started && !m_pending && !m_buf_valid;
    check("model imem_req", imem_req, exp_req);
    if (exp_req) check("model imem_addr", imem_addr, m_pc);
    check("model instr_valid", instr_valid, m_buf_valid);
    if (m_buf_valid) begin
      check("model instr", instr, m_buf);
      check("model instr_pc", instr_pc, m_buf_pc);
    end
  endtask

  task automatic model_update(input bit r, input logic [31:0] t, input bit ir,
                              input bit mr, input bit rv, input logic [31:0] rd);
    if (!m_started) begin
      m_started = 1;
      if (r) m_pc = t;
    end else if (m_buf_valid) begin
      if (r) begin
        m_buf_valid = 0;
        m_pc = t;
      end else if (ir) begin
        m_buf_valid = 0;
        m_pc = m_buf_pc + 32'd4;
      end
    end else if (m_pending) begin
      if (rv) begin
        m_pending = 0;
        if (m_stale || r) begin
          m_stale = 0;
          if (r) m_pc = t;
        end else begin
          m_buf_valid = 1;
          m_buf = rd;
          m_buf_pc = m_pc;
        end
      end else if (r) begin
        m_pc = t;
        m_stale = 1;
      end
    end else begin
      if (mr) begin
        m_pending = 1;
        m_stale = r;
      end
      if (r) m_pc = t;
    end
  endtask

  // One clock cycle: compare at the negedge, drive inputs, advance the model.
  task automatic step(input bit r, input logic [31:0] tgt, input bit ir, input bit mr);
    bit          rv, dut_req;
    logic [31:0] rd, dut_addr;
    compare_model();
    rv = 0;
    rd = '0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        rv = 1;
        rd = mem_data;
      end else begin
        mem_cnt--;
      end
    end
    redirect        = r;
    redirect_target = tgt;
    instr_ready     = ir;
    imem_ready      = mr;
    imem_rvalid     = rv;
    imem_rdata      = rd;
    dut_req         = imem_req;
    dut_addr        = imem_addr;
    @(posedge clk);
    if (rv) mem_busy = 0;
    if (dut_req && mr) begin
      mem_busy = 1;
      mem_cnt  = mem_delay;
      if (mem_fixed) mem_data = mem_fixed_data;
      else if (mem_rand) mem_data = $urandom;
      else mem_data = dut_addr ^ 32'hC0DE_0013;
      mem_fixed = 0;
    end
    model_update(r, tgt & 32'hFFFF_FFFC, ir, mr, rv, rd);
    @(negedge clk);
  endtask

  task automatic apply_reset_now();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset imem_req", imem_req, 0);
    check("reset instr_valid", instr_valid, 0);
    check("reset imem_addr", imem_addr, RESET_PC);
    redirect    = 0;
    instr_ready = 0;
    imem_ready  = 0;
    imem_rvalid = 0;
    imem_rdata  = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Step with memory stalled until a request appears; no instruction may surface.
  task automatic wait_req(input logic [31:0] exp_addr, input string name);
    int n;
    bit saw_valid;
    n = 0;
    saw_valid = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      if (instr_valid === 1'b1) saw_valid = 1;
      step(0, 32'h0, 1, 0);
      n++;
    end
    check({name, " req seen"}, imem_req, 1);
    check({name, " addr"}, imem_addr, exp_addr);
    check({name, " no instr"}, saw_valid, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    redirect = 0; redirect_target = '0; instr_ready = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    mem_delay = 0; mem_rand = 0; mem_fixed_data = '0;
    #2;
    apply_reset_now();
    check("reset instr", instr, 32'h0000_0013);
    check("reset instr_pc", instr_pc, 32'h0);

    // Zero-wait memory: one instruction every 3 cycles starting at 0.
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 1) begin
        check("seq imem_req", imem_req, 1);
        check("seq imem_addr", imem_addr, (i / 3) * 4);
      end
      if (i % 3 == 0 && i > 0) begin
        check("seq instr_valid", instr_valid, 1);
        check("seq instr_pc", instr_pc, ((i / 3) - 1) * 4);
      end
      step(0, 32'h0, 1, 1);
    end

    // Backpressure with a known word buffered at 0xC.
    mem_fixed = 1;
    mem_fixed_data = 32'h0050_0093;
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp instr_valid", instr_valid, 1);
      check("bp instr", instr, 32'h0050_0093);
      check("bp instr_pc", instr_pc, 32'hC);
      check("bp imem_req", imem_req, 0);
      step(0, 32'h0, 0, 1);
    end
    step(0, 32'h0, 1, 1);
    check("bp resume req", imem_req, 1);
    check("bp resume addr", imem_addr, 32'h10);

    // Redirect while waiting on a slow response.
    mem_delay = 3;
    step(0, 32'h0, 1, 1);
    step(1, 32'h100, 1, 0);
    wait_req(32'h100, "redirect in WAIT");

    // Redirect in the same cycle as the response.
    mem_delay = 0;
    step(0, 32'h0, 1, 1);
    step(1, 32'h300, 1, 0);
    wait_req(32'h300, "redirect with rvalid");

    // Redirect together with instr_ready while FULL; target low bits dropped.
    step(0, 32'h0, 1, 1);
    step(0, 32'h0, 0, 0);
    check("full instr_valid", instr_valid, 1);
    check("full instr_pc", instr_pc, 32'h300);
    step(1, 32'h203, 1, 0);
    check("full redirect valid", instr_valid, 0);
    check("full redirect req", imem_req, 1);
    check("full redirect addr", imem_addr, 32'h200);

    // PC wrap from the top of the address space.
    step(1, 32'hFFFF_FFFF, 0, 0);
    check("wrap target addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 0);
    check("wrap instr_pc", instr_pc, 32'hFFFF_FFFC);
    step(0, 32'h0, 1, 0);
    check("wrap next req", imem_req, 1);
    check("wrap next addr", imem_addr, 32'h0);

    // Reset while a request is outstanding.
    mem_delay = 2;
    step(0, 32'h0, 0, 1);
    check("wait imem_req", imem_req, 0);
    apply_reset_now();
    wait_req(RESET_PC, "restart after reset");

    // Randomized traffic.
    mem_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t;
      int sel;
      if ($urandom_range(0, 299) == 0) apply_reset_now();
      sel = $urandom_range(0, 9);
      if (sel == 0) t = 32'hFFFF_FFFC;
      else if (sel == 1) t = 32'hFFFF_FFF9;
      else t = $urandom;
      mem_delay = $urandom_range(0, 3);
      step($urandom_range(0, 7) == 0, t, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
